mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning memory data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied fetch cycles that forces a fetch grant; legal range 1..15.
REQ-004 Clock  input  1  single system clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 FetchReq  input  1  instruction-fetch read request, held until granted.
REQ-007 FetchAddr  input  ADDR_W  fetch address, stable while FetchReq high.
REQ-008 FetchGnt  output  1  fetch request accepted this cycle.
REQ-009 FetchValid  output  1  FetchData valid this cycle.
REQ-010 FetchData  output  DATA_W  fetch read data.
REQ-011 DataReq  input  1  load/store request, held until granted.
REQ-012 DataWE  input  1  1 = store, 0 = load; stable while DataReq high.
REQ-013 DataAddr  input  ADDR_W  load/store address.
REQ-014 DataWData  input  DATA_W  store data.
REQ-015 DataGnt  output  1  load/store accepted this cycle.
REQ-016 DataValid  output  1  DataRData valid this cycle (loads only).
REQ-017 DataRData  output  DATA_W  load read data.
REQ-018 MemEN  output  1  memory port enable.
REQ-019 MemWE  output  1  memory port write enable.
REQ-020 MemAddr  output  ADDR_W  memory port address.
REQ-021 MemWData  output  DATA_W  memory port write data.
REQ-022 MemRData  input  DATA_W  synchronous memory read data, valid one cycle after an enabled read.
REQ-023 Busy  output  1  any request pending or any read response outstanding.

Function
REQ-024 At most one of FetchGnt/DataGnt SHALL be high in any cycle; grants are combinational from current requests and registered state.
REQ-025 Default priority: DataReq wins over FetchReq.
REQ-026 A 4-bit starvation counter SHALL increment each cycle FetchReq=1 and FetchGnt=0, saturating at STARVE_MAX, and clear to 0 on FetchGnt.
REQ-027 When counter = STARVE_MAX and FetchReq=1, fetch SHALL be granted regardless of DataReq.
REQ-028 A lone request SHALL be granted in the same cycle it is asserted (zero-cycle grant).
REQ-029 On any grant: MemEN=1, MemAddr/MemWE/MemWData from the granted requester; fetch forces MemWE=0, MemWData=0.
REQ-030 With no grant: MemEN=0, MemWE=0, MemAddr=0, MemWData=0.
REQ-031 A registered response tag (NONE/FETCH/LOAD) SHALL record the granted read; stores record NONE.
REQ-032 Cycle after a fetch grant: FetchValid=1, FetchData=MemRData; after a load grant: DataValid=1, DataRData=MemRData; otherwise Valid=0, Data outputs=0.
REQ-033 Read latency SHALL be exactly 1 cycle from grant to Valid; back-to-back grants SHALL sustain one transfer per cycle.
REQ-034 Stores complete in the grant cycle; no DataValid is produced for a store.
REQ-035 Requester dropping Req before grant SHALL be treated as withdrawal; no memory access occurs.
REQ-036 Busy = FetchReq | DataReq | (tag != NONE).

Reset
REQ-037 While Reset=0: counter=0, tag=NONE, all Gnt/Valid/Mem outputs=0, Data outputs=0, Busy reflects only requests.
REQ-038 Reset asserted with a response outstanding SHALL discard that response; no Valid after Reset deassertion.
REQ-039 First grant possible in the first rising edge cycle after Reset deasserts.

Verification
REQ-040 Fetch only: FetchReq=1, FetchAddr=0x0010, MemRData=0xABCD next cycle -> FetchGnt same cycle, MemAddr=0x0010, FetchValid=1 with 0xABCD one cycle later.
REQ-041 Simultaneous: FetchReq=DataReq=1, DataWE=0, DataAddr=0x0200 -> DataGnt, MemAddr=0x0200, FetchGnt=0, counter=1.
REQ-042 Starvation: DataReq held 1 continuously with FetchReq=1, STARVE_MAX=4 -> DataGnt cycles 0-3, FetchGnt cycle 4, counter 0, DataGnt cycle 5.
REQ-043 Store: DataReq=1, DataWE=1, DataAddr=0x0030, DataWData=0x1234 -> MemEN=MemWE=1, MemWData=0x1234 same cycle, DataValid=0 next cycle.
REQ-044 Reset mid-op: load granted at cycle N, Reset=0 before edge N+1 -> DataValid=0 at N+1 and after release, tag=NONE.
REQ-045 Back-to-back: fetch grants 0x0000,0x0001,0x0002 consecutive cycles -> FetchValid high 3 consecutive cycles with matching MemRData.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store.
// Ports: fetch req/addr/gnt/valid/data, data req/we/addr/wdata/gnt/valid/rdata, mem port, busy.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_FETCH,
    TAG_LOAD
  } tag_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  tag_e       tag_q, tag_d;
  logic [3:0] starve_q, starve_d;
  logic       force_f;

  // Grants are gated by rst_n so nothing reaches memory while held in reset.
  always_comb begin
    force_f   = fetch_req && (starve_q == SMAX);
    fetch_gnt = rst_n && fetch_req && (force_f || !data_req);
    data_gnt  = rst_n && data_req && !force_f;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    unique case (1'b1)
      fetch_gnt: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
        tag_d    = TAG_FETCH;
      end
      data_gnt: begin
        mem_en    = 1'b1;
        mem_we    = data_we;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        tag_d     = data_we ? TAG_NONE : TAG_LOAD;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fetch_gnt)
      starve_d = '0;
    else if (fetch_req && starve_q != SMAX)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q    <= TAG_NONE;
      starve_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    fetch_valid = (tag_q == TAG_FETCH);
    data_valid  = (tag_q == TAG_LOAD);
    fetch_data  = fetch_valid ? mem_rdata : '0;
    data_rdata  = data_valid ? mem_rdata : '0;
    busy        = fetch_req | data_req | (tag_q != TAG_NONE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector-table plus scoreboard bench for mem_port_arbiter.
// Read responses are queued at grant time and checked the following cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, data_req, data_we;
  logic [15:0] fetch_addr, data_addr, data_wdata, mem_rdata;
  logic        fetch_gnt, fetch_valid, data_gnt, data_valid;
  logic [15:0] fetch_data, data_rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we, busy;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_valid(data_valid),
    .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    logic        freq;
    logic [15:0] faddr;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [15:0] dwdata;
    logic        efg;
    logic        edg;
    logic        emwe;
    logic [15:0] emaddr;
    logic [15:0] emwdata;
  } vec_t;

  typedef struct {
    logic fv;
    logic dv;
  } rsp_t;

  rsp_t rsp_q[$];
  int   passed = 0;
  int   total  = 0;
  vec_t vt[21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  function automatic vec_t mk(
    input logic fr, input logic [15:0] fa,
    input logic dr, input logic we,
    input logic [15:0] da, input logic [15:0] dw,
    input logic efg, input logic edg, input logic emwe,
    input logic [15:0] ema, input logic [15:0] emw);
    vec_t v;
    v.freq = fr; v.faddr = fa; v.dreq = dr; v.dwe = we;
    v.daddr = da; v.dwdata = dw;
    v.efg = efg; v.edg = edg; v.emwe = emwe;
    v.emaddr = ema; v.emwdata = emw;
    return v;
  endfunction

  task automatic step(input vec_t v, input logic [15:0] rd,
                      input string tag);
    rsp_t e;
    rsp_t n;
    @(negedge clk);
    fetch_req  = v.freq;
    fetch_addr = v.faddr;
    data_req   = v.dreq;
    data_we    = v.dwe;
    data_addr  = v.daddr;
    data_wdata = v.dwdata;
    mem_rdata  = rd;
    #1;
    if (rsp_q.size() == 0) begin
      chk({tag, " sb_empty"}, 1, 0);
      e.fv = 1'b0;
      e.dv = 1'b0;
    end else begin
      e = rsp_q.pop_front();
    end
    chk({tag, " fvalid"}, fetch_valid, e.fv);
    chk({tag, " fdata"}, fetch_data, e.fv ? rd : 16'h0);
    chk({tag, " dvalid"}, data_valid, e.dv);
    chk({tag, " ddata"}, data_rdata, e.dv ? rd : 16'h0);
    chk({tag, " fgnt"}, fetch_gnt, v.efg);
    chk({tag, " dgnt"}, data_gnt, v.edg);
    chk({tag, " men"}, mem_en, v.efg | v.edg);
    chk({tag, " mwe"}, mem_we, v.emwe);
    chk({tag, " maddr"}, mem_addr, v.emaddr);
    chk({tag, " mwdata"}, mem_wdata, v.emwdata);
    chk({tag, " busy"}, busy, v.freq | v.dreq | e.fv | e.dv);
    n.fv = v.efg;
    n.dv = v.edg & ~v.dwe;
    rsp_q.push_back(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    rsp_t z;
    z.fv = 1'b0;
    z.dv = 1'b0;

    vt[0]  = mk(1, 16'h0010, 0, 0, 0, 0, 1, 0, 0, 16'h0010, 0);
    vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 16'h0100, 1, 0, 16'h0200, 0, 0, 1, 0, 16'h0200, 0);
    vt[3]  = mk(1, 16'h0100, 0, 0, 0, 0, 1, 0, 0, 16'h0100, 0);
    vt[4]  = mk(0, 0, 1, 1, 16'h0030, 16'h1234,
                0, 1, 1, 16'h0030, 16'h1234);
    vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 6; i <= 9; i++)
      vt[i] = mk(1, 16'h0008, 1, 0, 16'h0400, 0,
                 0, 1, 0, 16'h0400, 0);
    vt[10] = mk(1, 16'h0008, 1, 0, 16'h0400, 0, 1, 0, 0, 16'h0008, 0);
    vt[11] = mk(1, 16'h0008, 1, 0, 16'h0400, 0, 0, 1, 0, 16'h0400, 0);
    vt[12] = mk(1, 16'h0008, 0, 0, 0, 0, 1, 0, 0, 16'h0008, 0);
    vt[13] = mk(1, 16'h0000, 0, 0, 0, 0, 1, 0, 0, 16'h0000, 0);
    vt[14] = mk(1, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 16'h0001, 0);
    vt[15] = mk(1, 16'h0002, 0, 0, 0, 0, 1, 0, 0, 16'h0002, 0);
    vt[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(1, 16'h0044, 1, 0, 16'h0600, 0, 0, 1, 0, 16'h0600, 0);
    vt[18] = mk(0, 16'h0044, 1, 0, 16'h0601, 0, 0, 1, 0, 16'h0601, 0);
    vt[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst_n      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h0010;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 16'h0020;
    data_wdata = 16'h5a5a;
    mem_rdata  = 16'hffff;
    repeat (3) @(negedge clk);
    #1;
    chk("rst fgnt", fetch_gnt, 0);
    chk("rst dgnt", data_gnt, 0);
    chk("rst men", mem_en, 0);
    chk("rst mwe", mem_we, 0);
    chk("rst maddr", mem_addr, 0);
    chk("rst mwdata", mem_wdata, 0);
    chk("rst fvalid", fetch_valid, 0);
    chk("rst dvalid", data_valid, 0);
    chk("rst fdata", fetch_data, 0);
    chk("rst busy", busy, 1);
    fetch_req = 1'b0;
    data_req  = 1'b0;
    #1;
    chk("rst busy idle", busy, 0);
    rst_n = 1'b1;
    rsp_q.delete();
    rsp_q.push_back(z);

    for (int i = 0; i < 21; i++) begin
      logic [15:0] rd;
      rd = (i == 1) ? 16'hABCD : 16'(16'hC000 + i * 16'h0101);
      step(vt[i], rd, $sformatf("v%0d", i));
    end

    // load granted, reset lands before the next edge
    @(negedge clk);
    data_req  = 1'b1;
    data_we   = 1'b0;
    data_addr = 16'h0050;
    mem_rdata = 16'h0;
    #1;
    chk("mid dgnt", data_gnt, 1);
    chk("mid maddr", mem_addr, 16'h0050);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid dgnt rst", data_gnt, 0);
    chk("mid men rst", mem_en, 0);
    chk("mid busy rst", busy, 1);
    data_req = 1'b0;
    @(negedge clk);
    mem_rdata = 16'hDEAD;
    #1;
    chk("mid dvalid", data_valid, 0);
    chk("mid ddata", data_rdata, 0);
    chk("mid busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post dvalid", data_valid, 0);
    chk("post ddata", data_rdata, 0);
    chk("post busy", busy, 0);
    rsp_q.delete();
    rsp_q.push_back(z);
    step(mk(1, 16'h0077, 1, 0, 16'h0700, 0, 0, 1, 0, 16'h0700, 0),
         16'h1357, "post0");
    step(mk(0, 16'h0077, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h2468, "post1");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 16'h9abc, "post2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
